// File: rtl/beat_sequencer_if.sv
// Bus bundle between the beat sequencer and its neighbours: word/digit timing
// pulses and operator controls in; beat, digit and status flags out.
interface beat_sequencer_if #(
    parameter int DIGIT_BITS = 5
);
    logic                  w_BO;
    logic                  w_DP;
    logic                  w_SS;
    logic                  w_KSP;
    logic                  w_STOP_INSTR;
    logic [1:0]            b_BEAT;
    logic [DIGIT_BITS-1:0] b_DIGIT;
    logic                  w_SCAN;
    logic                  w_ACTION;
    logic                  w_RUNNING;
    logic                  w_SL;
    logic                  w_CYCLE_END;

    // The sequencer itself.
    modport slave (
        input  w_BO, w_DP, w_SS, w_KSP, w_STOP_INSTR,
        output b_BEAT, b_DIGIT, w_SCAN, w_ACTION, w_RUNNING, w_SL, w_CYCLE_END
    );

    // Whatever drives timing and controls and consumes the beat outputs.
    modport master (
        output w_BO, w_DP, w_SS, w_KSP, w_STOP_INSTR,
        input  b_BEAT, b_DIGIT, w_SCAN, w_ACTION, w_RUNNING, w_SL, w_CYCLE_END
    );
endinterface

// File: rtl/beat_sequencer.sv
// Beat sequencer: digit index within a word plus the four-beat instruction
// cycle (S1, A1, S2, A2), with stop/run switch, single-shot key and
// stop-instruction halting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | halted; waits for run switch or single-shot key press
// ARMED | start requested; waits for the next word boundary (w_BO)
// RUN   | continuous cycling; halts at end of A2 if switch is off
// SHOT  | one instruction cycle only; halts at end of A2
module beat_sequencer #(
    parameter int WORD_LENGTH = 20,
    parameter int DIGIT_BITS  = $clog2(WORD_LENGTH)
) (
    input logic              w_CLK,
    input logic              w_RST_N,
    beat_sequencer_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_SHOT  = 2'd3;

    localparam logic [DIGIT_BITS-1:0] DIGIT_LAST = DIGIT_BITS'(WORD_LENGTH - 1);

    logic [1:0]            state;
    logic [1:0]            beat;
    logic [DIGIT_BITS-1:0] digit;
    logic                  mode_shot;
    logic                  stop_latch;
    logic                  sl;
    logic                  cycle_end;
    logic                  ksp_q;
    logic                  ksp_rise;
    logic                  running;

    assign ksp_rise = bus.w_KSP & ~ksp_q;
    assign running  = (state == ST_RUN) || (state == ST_SHOT);

    // Digit counter: cleared at the word boundary, saturates at the last digit.
    // The key history also loads during reset so a key held through reset
    // does not count as a press.
    always_ff @(posedge w_CLK) begin
        ksp_q <= bus.w_KSP;
        if (!w_RST_N) begin
            digit <= '0;
        end else if (bus.w_BO) begin
            digit <= '0;
        end else if (bus.w_DP && (digit != DIGIT_LAST)) begin
            digit <= digit + 1'b1;
        end
    end

    // Start/stop state machine and beat advance; halts only at end of A2.
    always_ff @(posedge w_CLK) begin
        if (!w_RST_N) begin
            state      <= ST_IDLE;
            beat       <= 2'd0;
            mode_shot  <= 1'b0;
            stop_latch <= 1'b0;
            sl         <= 1'b0;
            cycle_end  <= 1'b0;
        end else begin
            cycle_end <= 1'b0;
            case (state)
                ST_IDLE: begin
                    beat       <= 2'd0;
                    stop_latch <= 1'b0;
                    if (bus.w_SS) begin
                        state     <= ST_ARMED;
                        mode_shot <= 1'b0;
                    end else if (ksp_rise) begin
                        state     <= ST_ARMED;
                        mode_shot <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    beat <= 2'd0;
                    // Dropping the switch before the cycle starts cancels a run request.
                    if (!mode_shot && !bus.w_SS) begin
                        state <= ST_IDLE;
                    end else if (bus.w_BO) begin
                        state <= mode_shot ? ST_SHOT : ST_RUN;
                        sl    <= 1'b0;
                    end
                end
                default: begin
                    if (bus.w_STOP_INSTR && (beat == 2'd1)) begin
                        stop_latch <= 1'b1;
                    end
                    if (bus.w_BO) begin
                        if (beat == 2'd3) begin
                            cycle_end <= 1'b1;
                            beat      <= 2'd0;
                            if (stop_latch) begin
                                state      <= ST_IDLE;
                                sl         <= 1'b1;
                                stop_latch <= 1'b0;
                            end else if (state == ST_SHOT || !bus.w_SS) begin
                                state      <= ST_IDLE;
                                stop_latch <= 1'b0;
                            end
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.b_BEAT      = beat;
    assign bus.b_DIGIT     = digit;
    assign bus.w_RUNNING   = running;
    assign bus.w_SCAN      = running & ~beat[0];
    assign bus.w_ACTION    = running & beat[0];
    assign bus.w_SL        = sl;
    assign bus.w_CYCLE_END = cycle_end;
endmodule
